// File: rtl/prog_loader.sv
// Boot-time instruction-memory loader: length-prefixed little-endian byte stream -> 32-bit imem writes.
// Optional trailer checksum enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_e;

    state_e            state_q;
    logic [15:0]       count_q;
    logic [1:0]        byte_idx_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [23:0]       word_buf_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              core_rst_q;
    logic              done_q;
    logic              error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    logic        ready_state_s;
    logic        accept_s;
    logic [15:0] cnt_new_s;
    logic        oversize_s;
    logic        last_word_s;

    // States in which the loader is willing to take a stream byte
    always_comb begin
        ready_state_s = 1'b0;
        case (state_q)
            CNT_LO:  ready_state_s = 1'b1;
            CNT_HI:  ready_state_s = 1'b1;
            DATA:    ready_state_s = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM:    ready_state_s = 1'b1;
`endif
            default: ready_state_s = 1'b0;
        endcase
    end

    assign byte_ready  = ~rst & ready_state_s;
    assign accept_s    = byte_valid & byte_ready;
    assign cnt_new_s   = {byte_data, count_q[7:0]};
    assign oversize_s  = 32'(cnt_new_s) > 32'(MAX_WORDS);
    assign last_word_s = (32'(word_cnt_q) + 32'd1) == 32'(count_q);

    // Loader FSM with registered write port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CNT_LO;
            count_q    <= 16'h0000;
            byte_idx_q <= 2'd0;
            word_cnt_q <= '0;
            word_buf_q <= 24'h000000;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'h0000_0000;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                CNT_LO: begin
                    if (accept_s) begin
                        count_q[7:0] <= byte_data;
                        state_q      <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (accept_s) begin
                        count_q[15:8] <= byte_data;
                        if (oversize_s) begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end else if (cnt_new_s == 16'h0000) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_q <= CSUM;
`else
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
`endif
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_q      <= csum_add(sum_q, byte_data);
`endif
                        case (byte_idx_q)
                            2'd0: word_buf_q[7:0]   <= byte_data;
                            2'd1: word_buf_q[15:8]  <= byte_data;
                            2'd2: word_buf_q[23:16] <= byte_data;
                            2'd3: begin
                                wr_en_q    <= 1'b1;
                                wr_addr_q  <= word_cnt_q[ADDR_W-1:0];
                                wr_data_q  <= {byte_data, word_buf_q};
                                word_cnt_q <= word_cnt_q + 1'b1;
                                if (last_word_s) begin
                                    state_q <= DRAIN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                // The final write pulse is on the bus during this state
                DRAIN: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_q <= CSUM;
`else
                    state_q    <= DONE;
                    done_q     <= 1'b1;
                    core_rst_q <= 1'b0;
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept_s) begin
                        if (byte_data == sum_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                DONE: state_q <= DONE;
                ERR:  state_q <= ERR;
                default: begin
                    state_q <= ERR;
                    error_q <= 1'b1;
                end
            endcase
        end
    end

    // A pending write is suppressed while reset is asserted
    assign wr_en    = wr_en_q & ~rst;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign core_rst = core_rst_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a stream-level reference model.
module tb_prog_loader;
    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              core_rst;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int early_rel = 0;
    int stalls = 0;
    logic [ADDR_W-1:0] got_addr [0:4095];
    logic [31:0]       got_data [0:4095];
    logic [31:0]       stim_words [$];

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_rst(core_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Capture every imem write; flag any write seen after the core left reset
    always @(negedge clk) begin
        if (wr_en) begin
            got_addr[wr_total % 4096] = wr_addr;
            got_data[wr_total % 4096] = wr_data;
            wr_total = wr_total + 1;
            if (!core_rst) early_rel = early_rel + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", byte_ready, 1'b0);
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_core_rst", core_rst, 1'b1);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_error", error, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", byte_ready, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waited < 20) begin
            stalls++;
            waited++;
            @(negedge clk);
        end
        if (!byte_ready) check_eq("ready_timeout", byte_ready, 1'b1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Reference model: build the byte stream for stim_words, then compare writes and status
    task automatic do_load(input string tag, input int idle_max, input int csum_delta);
        logic [7:0]  s [$];
        logic [7:0]  sum;
        logic [15:0] n16;
        int n, base, early_base, lat, exp_lat, pay_stalls, nbytes;
        bit exp_err;
        n   = stim_words.size();
        n16 = 16'(n);
        sum = 8'h00;
        apply_reset();
        base       = wr_total;
        early_base = early_rel;
        stalls     = 0;
        s.push_back(n16[7:0]);
        s.push_back(n16[15:8]);
        foreach (stim_words[i]) begin
            for (int k = 0; k < 4; k++) begin
                s.push_back(stim_words[i][8*k +: 8]);
                sum = sum + stim_words[i][8*k +: 8];
            end
        end
        nbytes = s.size();
`ifdef PROG_LOADER_CHECKSUM_EN
        s.push_back(sum + 8'(csum_delta));
`endif
        exp_err = CSUM_EN && (csum_delta != 0);
        exp_lat = (CSUM_EN || n == 0) ? 1 : 2;
        pay_stalls = 0;
        foreach (s[i]) begin
            repeat ($urandom_range(idle_max, 0)) @(negedge clk);
            send_byte(s[i]);
            if (i == nbytes - 1) pay_stalls = stalls;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && !error && lat < 9);
        check_eq({tag, "_latency"}, lat, exp_lat);
        repeat (3) @(negedge clk);
        check_eq({tag, "_nwrites"}, wr_total - base, n);
        for (int i = 0; i < n && i < wr_total - base; i++) begin
            check_eq({tag, "_addr"}, got_addr[(base + i) % 4096], i);
            check_eq({tag, "_data"}, got_data[(base + i) % 4096], stim_words[i]);
        end
        check_eq({tag, "_done"}, done, !exp_err);
        check_eq({tag, "_error"}, error, exp_err);
        check_eq({tag, "_core_rst"}, core_rst, exp_err);
        check_eq({tag, "_ready_end"}, byte_ready, 1'b0);
        check_eq({tag, "_payload_stalls"}, pay_stalls, 0);
        check_eq({tag, "_early_release"}, early_rel - early_base, 0);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);

        stim_words = '{32'h0000_0013, 32'hDEAD_BEEF};
        do_load("basic", 0, 0);
        do_load("idle", 3, 0);

        stim_words.delete();
        do_load("zero", 2, 0);

        for (int t = 0; t < 6; t++) begin
            stim_words.delete();
            repeat ($urandom_range(6, 1)) stim_words.push_back($urandom);
            do_load("rand", 3, 0);
        end

        stim_words.delete();
        for (int i = 0; i < MAX_WORDS; i++) stim_words.push_back($urandom);
        do_load("max", 0, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        stim_words = '{32'h0403_0201};
        do_load("badsum", 0, 1);
`endif

        // Oversized count: error one cycle after the high count byte, stream ignored after
        apply_reset();
        base = wr_total;
        send_byte(8'h01);
        send_byte(8'h04);
        @(negedge clk);
        check_eq("over_error", error, 1'b1);
        check_eq("over_ready", byte_ready, 1'b0);
        check_eq("over_done", done, 1'b0);
        check_eq("over_core_rst", core_rst, 1'b1);
        byte_valid = 1'b1;
        repeat (8) begin
            byte_data = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check_eq("over_nwrites", wr_total - base, 0);
        check_eq("over_error_sticky", error, 1'b1);
        check_eq("over_done_after", done, 1'b0);

        // Reset in the cycle right after byte 3 is accepted: that write must not appear
        apply_reset();
        base = wr_total;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstcyc_wr_en", wr_en, 1'b0);
        check_eq("rstcyc_nwrites", wr_total - base, 0);

        // Reset mid-load after 5 payload bytes, then a fresh single-word load
        apply_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        stim_words = '{32'hDDCC_BBAA};
        do_load("midrst", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
